des_keygen_dec: RTL
===================

Name: des_keygen_dec

Overview:
Iterative DES decryption key schedule. It emits the 16 round keys in reverse order (K16 first, K1 last), one per clock, by rotating the C/D halves right.
It is the decrypt-direction counterpart of the combinational encryption keygen/counter pair. It has its own internal round sequencer, so the DES round datapath can consume keys directly in decrypt mode.

Parameters:
None. The DES tables (PC-1, PC-2, rotate schedule) are fixed constants.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
key  input  64  DES key, bit 63 = DES bit 1; parity bits ignored; sampled on the accepted start edge only
busy  output  1  high from the cycle after an accepted start through the DONE cycle
key_valid  output  1  high while round_key/round_idx are valid (ROUND state)
round_idx  output  5  decryption round number 1..16; 0 when not in ROUND
round_key  output  48  PC-2(C,D) of current decryption round; 0 when key_valid=0
done  output  1  one-cycle pulse after round 16

Behaviour:
- Clock is clk; reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge, including mid-operation): state=IDLE, C/D=0, counter=0, all outputs 0. Reset dominates start.
- States: IDLE, ROUND, DONE.
- IDLE:
  - start=1 at an edge: C,D <= PC-1(key) split 28/28, cnt <= 1, state <= ROUND.
  - start=0: stay in IDLE.
- ROUND:
  - key_valid=1, round_idx=cnt, round_key=PC-2({C,D}).
  - Outputs are combinational from registers, so round 1 is valid the cycle after start (latency 1).
  - On each edge with cnt<16: C,D each rotate right by R[cnt], cnt <= cnt+1.
  - R[1..15] = 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Total 27; with the 28-bit wrap this yields K1 at round 16.
  - On the edge with cnt=16: state <= DONE, cnt <= 0. C/D need not rotate.
- DONE: done=1, busy=1, key_valid=0 for exactly one cycle, then IDLE.
- start while busy (ROUND or DONE) is ignored. No queuing; the key input is not re-sampled.
- Back-to-back operation: start asserted in the first IDLE cycle after DONE is accepted. Minimum period is 18 cycles (accept edge, 16 ROUND cycles, 1 DONE cycle).
- Key changes on the key input after acceptance have no effect on the current schedule.
- Round sequence produced: round_idx 1..16 carries K16..K1 of the equivalent encryption schedule.

Optional Feature:
Macro: DES_KEYGEN_DEC_WEAKKEY_EN.
- Defined:
  - Adds output weak_key (1 bit).
  - Registered on the accepted start edge: 1 iff PC-1(key) has C all-0 or all-1 AND D all-0 or all-1, i.e. one of the four DES weak keys regardless of parity.
  - Held until the next accepted start; cleared by reset.
  - The key schedule itself is unaffected.
- Not defined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then start with key=64'h133457799BBCDFF1:
  - key_valid rises 1 cycle after start.
  - round 1 = 48'hCB3D8B0E17F5, round 2 = 48'hBF918D3D3F0A.
  - round 15 = 48'h79AED9DBC9E5, round 16 = 48'h1B02EFFC7072.
  - done pulses once on the 17th cycle after start, then IDLE.
- Cross-check: for 4 random keys, the decrypt round i key equals the encryption keygen output at cnt=17-i, for all i.
- start re-asserted during rounds 3..10 with a different key -> sequence unchanged; busy stays high; done count = 1.
- rst_n=0 for one edge during round 7 -> next cycle all outputs 0, state IDLE. A following start produces a full, correct 16-key sequence.
- start held high continuously with key 133457799BBCDFF1 -> new run accepted on the first IDLE cycle after each DONE; period 18 cycles; every run identical.
- With DES_KEYGEN_DEC_WEAKKEY_EN:
  - keys 0101010101010101, FEFEFEFEFEFEFEFE, E0E0E0E0F1F1F1F1, 1F1F1F1F0E0E0E0E -> weak_key=1; all 16 round keys identical within each run.
  - key 133457799BBCDFF1 -> weak_key=0.

Source files
------------

// File: rtl/des_keygen_dec_if.sv
// des_keygen_dec_if: request/response bundle for the DES decrypt key schedule.
// Optional output weak_key exists only when DES_KEYGEN_DEC_WEAKKEY_EN is defined.
//
// Handshake: start is a one-cycle request taken only while the block is idle
// (busy=0); key is captured on that same edge. round_key/round_idx are valid
// exactly while key_valid=1, one key per cycle, with no backpressure. done is a
// single-cycle pulse after the last key; busy covers accept+1 through done.
interface des_keygen_dec_if;
    logic        start;
    logic [63:0] key;
    logic        busy;
    logic        key_valid;
    logic [4:0]  round_idx;
    logic [47:0] round_key;
    logic        done;
    logic [1:0]  dbg_state;
`ifdef DES_KEYGEN_DEC_WEAKKEY_EN
    logic        weak_key;
`endif

    modport master (
        output start, key,
        input  busy, key_valid, round_idx, round_key, done, dbg_state
`ifdef DES_KEYGEN_DEC_WEAKKEY_EN
        , input weak_key
`endif
    );

    modport slave (
        input  start, key,
        output busy, key_valid, round_idx, round_key, done, dbg_state
`ifdef DES_KEYGEN_DEC_WEAKKEY_EN
        , output weak_key
`endif
    );
endinterface

// File: rtl/des_keygen_dec.sv
// des_keygen_dec: iterative DES decryption key schedule. Loads PC-1(key) on
// an accepted start, then emits K16..K1 (one per cycle) by rotating C/D right.
// Optional macro DES_KEYGEN_DEC_WEAKKEY_EN adds a registered weak_key flag.
// dbg_state exposes the FSM state (0=IDLE, 1=ROUND, 2=DONE).
module des_keygen_dec (
    input  logic          clk,
    input  logic          rst_n,
    des_keygen_dec_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} state_t;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Table entries use DES numbering: bit 1 is the MSB of the source vector.
    function automatic logic [55:0] f_pc1(input logic [63:0] k);
        logic [55:0] v;
        v = '0;
        for (int j = 0; j < 56; j++) v[55-j] = k[64-PC1_TAB[j]];
        return v;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] cd);
        logic [47:0] v;
        v = '0;
        for (int j = 0; j < 48; j++) v[47-j] = cd[56-PC2_TAB[j]];
        return v;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [4:0]  r_cnt;
    logic [55:0] w_pc1;
    logic        w_rot1;

    assign w_pc1 = f_pc1(bus.key);
    // C0/D0 already equal C16/D16 (28 total shifts), so decrypt starts from
    // PC-1 directly; single-step rounds fall where encryption used shift 1.
    assign w_rot1 = (r_cnt == 5'd1) || (r_cnt == 5'd8) || (r_cnt == 5'd15);

    // Next-state logic for the IDLE -> ROUND x16 -> DONE sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_ROUND;
            S_ROUND: if (r_cnt == 5'd16) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register plus C/D/counter datapath; reset dominates start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_c   <= w_pc1[55:28];
                        r_d   <= w_pc1[27:0];
                        r_cnt <= 5'd1;
                    end
                end
                S_ROUND: begin
                    if (r_cnt < 5'd16) begin
                        r_c   <= w_rot1 ? {r_c[0], r_c[27:1]} : {r_c[1:0], r_c[27:2]};
                        r_d   <= w_rot1 ? {r_d[0], r_d[27:1]} : {r_d[1:0], r_d[27:2]};
                        r_cnt <= r_cnt + 5'd1;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state so round 1 appears one cycle after start.
    always_comb begin
        bus.busy      = 1'b0;
        bus.key_valid = 1'b0;
        bus.round_idx = '0;
        bus.round_key = '0;
        bus.done      = 1'b0;
        bus.dbg_state = r_state;
        case (r_state)
            S_ROUND: begin
                bus.busy      = 1'b1;
                bus.key_valid = 1'b1;
                bus.round_idx = r_cnt;
                bus.round_key = f_pc2({r_c, r_d});
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DES_KEYGEN_DEC_WEAKKEY_EN
    logic r_weak;

    // Weak-key flag: both PC-1 halves uniform; captured per accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_weak <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_weak <= (&w_pc1[55:28] || ~|w_pc1[55:28]) &&
                      (&w_pc1[27:0]  || ~|w_pc1[27:0]);
        end
    end

    assign bus.weak_key = r_weak;
`endif
endmodule
